// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : TinyCPU instruction fetch stage. Holds the PC and drives the
//                asynchronous-read instruction memory address. It captures
//                the returned word each cycle into a small FIFO of
//                {inst, pc} that feeds decode over a valid/ready handshake.
//                It also handles redirects and stops fetching after a HALT.
//  Ports       : clk            - clock, rising edge
//                rst_n          - synchronous active-low reset
//                imem_addr      - instruction memory address (= PC)
//                imem_inst      - word returned by instruction memory
//                redirect_valid - load redirect_pc and flush the buffer
//                redirect_pc    - redirect target
//                out_valid      - buffer head holds a valid instruction
//                out_ready      - decode accepts the head this cycle
//                out_inst       - head instruction
//                out_pc         - PC of the head instruction
//                halted         - a HALT has been fetched, fetch stopped
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_halted;

    // Buffer storage carries no reset: only pointers and count define validity.
    logic [INST_W-1:0] r_buf_inst [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc   [DEPTH];

    logic w_pop;
    logic w_push;
    logic w_is_halt;

    assign imem_addr = r_pc;
    assign out_valid = (r_count != '0);
    assign out_inst  = r_buf_inst[r_rptr];
    assign out_pc    = r_buf_pc[r_rptr];
    assign halted    = r_halted;

    assign w_pop     = out_valid && out_ready;
    // A full buffer can still accept a word when the head leaves this cycle.
    assign w_push    = !r_halted && ((r_count < c_DEPTH) || w_pop);
    assign w_is_halt = (imem_inst[INST_W-1 -: 4] == HALT_OP);

    // Control state: reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + ADDR_W'(1);
                r_wptr <= r_wptr + PTR_W'(1);
                if (w_is_halt) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && w_push) begin
            r_buf_inst[r_wptr] <= imem_inst;
            r_buf_pc[r_wptr]   <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A behavioural
//                instruction memory answers imem_addr combinationally.
//                Expected values are hand-computed from the memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_inst;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [7:0]  out_pc;
    logic        halted;

    logic [15:0] mem [256];

    int n_checks;
    int n_errs;

    assign imem_inst = mem[imem_addr];

    fetch_unit #(
        .ADDR_W   (8),
        .INST_W   (16),
        .RESET_PC (8'h00),
        .HALT_OP  (4'hF),
        .DEPTH    (2)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two reset edges; returns at a falling edge with rst_n released.
    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = ready;
        tick();
        tick();
        check_eq("rst_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_halted", {31'd0, halted},    32'd0);
        check_eq("rst_addr",   {24'd0, imem_addr}, 32'h00);
        rst_n = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] inst, input logic [7:0] pc);
        check_eq({tag, "_v"},    {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_inst"}, {16'd0, out_inst},  {16'd0, inst});
        check_eq({tag, "_pc"},   {24'd0, out_pc},    {24'd0, pc});
    endtask

    initial begin
        n_checks       = 0;
        n_errs         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        @(negedge clk);

        // Streaming: head after release edge k is mem[k] / pc k.
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_head("stream", 16'h1000 + 16'(k), 8'(k));
        end

        // Backpressure: fill to two entries, PC parks at 2.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) tick();
        check_eq("bp_addr", {24'd0, imem_addr}, 32'h02);
        check_head("bp_hold", 16'h1000, 8'h00);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_head("bp_drain", 16'h1000 + 16'(k), 8'(k));
            tick();
        end

        // Redirect while streaming, when head pc is 3.
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) tick();
        check_eq("rd_pre_pc", {24'd0, out_pc}, 32'h03);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check_eq("rd_bubble", {31'd0, out_valid}, 32'd0);
        check_eq("rd_addr",   {24'd0, imem_addr}, 32'h40);
        tick();
        check_head("rd_tgt", 16'h1040, 8'h40);
        tick();
        check_head("rd_next", 16'h1041, 8'h41);

        // Redirect while the buffer is full and stalled flushes both entries.
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rdf_full_v", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        tick();
        redirect_valid = 1'b0;
        check_eq("rdf_flush", {31'd0, out_valid}, 32'd0);
        tick();
        check_head("rdf_tgt", 16'h1080, 8'h80);

        // Halt at mem[5].
        mem[5] = 16'hF000;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_head("halt_pre", mem[k], 8'(k));
        end
        check_eq("halt_low", {31'd0, halted}, 32'd0);
        tick();
        check_head("halt_word", 16'hF000, 8'h05);
        check_eq("halt_set", {31'd0, halted}, 32'd1);
        tick();
        check_eq("halt_empty", {31'd0, out_valid}, 32'd0);
        check_eq("halt_addr",  {24'd0, imem_addr}, 32'h06);
        tick();
        tick();
        check_eq("halt_addr2", {24'd0, imem_addr}, 32'h06);
        check_eq("halt_empty2", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        tick();
        redirect_valid = 1'b0;
        check_eq("halt_clr", {31'd0, halted}, 32'd0);
        tick();
        check_head("halt_resume", 16'h1000, 8'h00);
        mem[5] = 16'h1005;

        // PC wrap from FF to 00.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_head("wrap_fe", 16'h10FE, 8'hFE);
        tick();
        check_head("wrap_ff", 16'h10FF, 8'hFF);
        tick();
        check_head("wrap_00", 16'h1000, 8'h00);
        tick();
        check_head("wrap_01", 16'h1001, 8'h01);

        // Reset mid-operation with a full buffer and a concurrent redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mid_full_v", {31'd0, out_valid}, 32'd1);
        check_eq("mid_addr_pre", {24'd0, imem_addr}, 32'h12);
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h55;
        tick();
        check_eq("mid_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("mid_halted", {31'd0, halted},    32'd0);
        check_eq("mid_addr",   {24'd0, imem_addr}, 32'h00);
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        check_head("mid_resume", 16'h1000, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the TinyCPU front end. Holds the program counter, drives the address of the asynchronous-read instruction memory, and captures the returned 16-bit word each cycle. Captured instructions and their PCs go into a small buffer that feeds decode over a valid/ready handshake. The stage also supports redirects (branch/jump) and stops fetching after a HALT instruction.

## Interface
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `INST_W`, default 16: instruction width.
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `HALT_OP`, default 4'hF: opcode (instruction bits [15:12]) that halts fetch.
- `DEPTH`, default 2: fetch buffer entries; must be a power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `imem_addr` output ADDR_W: instruction-memory address; combinationally equal to the PC register.
- `imem_inst` input INST_W: word returned combinationally by instruction memory for `imem_addr`.
- `redirect_valid` input 1: load a new PC and flush the buffer.
- `redirect_pc` input ADDR_W: target PC, sampled when `redirect_valid`=1.
- `out_valid` output 1: buffer head holds a valid instruction.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_inst` output INST_W: head instruction.
- `out_pc` output ADDR_W: PC the head instruction was fetched from.
- `halted` output 1: a HALT has been fetched; fetch is stopped.

## Operation
- State:
  - `pc`.
  - DEPTH-entry FIFO of {inst, pc}, with read/write pointers and a count of 0..DEPTH.
  - `halted` flag.
- Pop: `out_valid && out_ready`.
- Push allowed when `!halted && (count < DEPTH || pop)`. A push writes {`imem_inst`, `pc`} into the FIFO and sets `pc <= pc + 1`.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF wraps to 8'h00, with no flag and no stall.
- Halt:
  - If the pushed word has bits [15:12] == `HALT_OP`, the word itself is still pushed and `halted` is set.
  - `pc` still advances past the HALT.
  - No further pushes occur until a redirect or reset.
- Redirect (`redirect_valid`=1) has highest priority:
  - FIFO is flushed (count=0, pointers=0).
  - `pc <= redirect_pc` and `halted <= 0`.
  - No push occurs that cycle; any simultaneous pop is discarded, with no side effect.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Outputs `out_inst`/`out_pc` come from the FIFO head. While `out_valid && !out_ready` they are held stable.
- FIFO contents are not cleared on flush or reset. Only pointers and count are reset, so `out_inst`/`out_pc` are don't-care while `out_valid`=0.

## Timing
- Reset, on any edge with `rst_n`=0 (mid-operation included):
  - `pc`=RESET_PC, so `imem_addr`=RESET_PC.
  - count=0, `out_valid`=0, `halted`=0.
  - All in-flight instructions are dropped. Reset overrides redirect.
- Fetch latency is one cycle. On the first edge with `rst_n`=1, mem[RESET_PC] is pushed, so `out_valid`=1 right after that edge.
- Throughput: one instruction per cycle while `out_ready`=1 and no halt.
- Backpressure: with `out_ready`=0, the FIFO fills to DEPTH, then `pc` holds and `imem_addr` is stable.
- Redirect: on the edge where it is sampled, `out_valid` drops to 0. mem[`redirect_pc`] is pushed on the following edge, so the redirect penalty is 1 bubble cycle.
- `halted` rises on the same edge that pushes the HALT word. Instructions already buffered still drain normally.

## Test plan
- Streaming:
  - Stimulus: mem[i]=16'h1000+i; release reset; hold `out_ready`=1.
  - Required: after release edge k (k=0,1,2,…), `out_inst`=16'h1000+k and `out_pc`=k, with `out_valid` continuously 1.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after reset, then 1.
  - Required: count saturates at 2 and `imem_addr` holds at 2. Head stays 16'h1000/pc 0 until ready. Then 16'h1000, 16'h1001, 16'h1002, … appear in order with no loss or duplication.
- Redirect:
  - Stimulus: with `out_ready`=1, assert `redirect_valid` with `redirect_pc`=8'h40 when `out_pc`=3.
  - Required: `out_valid`=0 for one cycle, then `out_inst`=mem[0x40], `out_pc`=0x40, followed by 0x41…
  - Also: a redirect while the FIFO is full with `out_ready`=0 flushes both entries.
- Halt:
  - Stimulus: mem[5]=16'hF000, `out_ready`=1.
  - Required: after pc 0–5 are delivered, `halted`=1, `out_valid`=0, and `imem_addr` stays at 6. A later redirect to 8'h00 clears `halted` and resumes from mem[0].
- Wrap:
  - Stimulus: redirect to 8'hFE.
  - Required: delivered PCs are FE, FF, 00, 01 with the matching instructions.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 for one edge while the FIFO holds 2 entries and a redirect is asserted.
  - Required: after that edge, `out_valid`=0, `halted`=0, `imem_addr`=RESET_PC. The redirect is ignored.
